// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and defaults for the CPU run/step/breakpoint controller
// Contents:
//   state_t    2-bit controller state encoding
//   CNT_W_DEF  default width of the enabled-cycle counter
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BRK  = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - push-button synchronizer with one-cycle rising-edge pulse
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   btn    in   raw button level, asynchronous to clk
//   pulse  out  one-cycle pulse per rising edge of btn
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       lvl_q;
  logic       pulse_q;

  // Two synchronizer flops, a history flop for edge detect, and a registered
  // pulse: a level first sampled at edge k yields a pulse in the cycle after
  // edge k+2. All flops clear on reset, so a button held through reset
  // release still produces exactly one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      lvl_q   <= sync_q[1];
      pulse_q <= sync_q[1] & ~lvl_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint controller producing the pipeline enable
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   run        in   continuous-run request level
//   step       in   raw step push-button level (asynchronous)
//   brk_en     in   breakpoint enable
//   brk_addr   in   breakpoint fetch address
//   pc         in   current fetch address
//   stall      in   load-use stall from hazard unit
//   cpu_en     out  enable for PC and all pipeline register banks
//   halted     out  high in HALT or BRK
//   brk_hit    out  high in BRK
//   cycle_cnt  out  number of enabled cycles, wrapping
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             brk_en,
  input  logic [31:0]      brk_addr,
  input  logic [31:0]      pc,
  input  logic             stall,
  output logic             cpu_en,
  output logic             halted,
  output logic             brk_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_t state_q;
  state_t state_d;
  logic   skip_q;
  logic   step_pulse;
  logic   bp_match;

  btn_edge u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (step),
    .pulse (step_pulse)
  );

  // skip suppresses the match for the first enabled cycle after a resume so
  // execution can leave brk_addr once.
  assign bp_match = brk_en & (pc == brk_addr) & ~skip_q;

  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    case (state_q)
      S_HALT: begin
        if (run)             state_d = S_RUN;
        else if (step_pulse) state_d = S_STEP;
      end
      S_RUN: begin
        // Drop the enable in the match cycle so the breakpoint instruction
        // is held in IF and never reaches ID.
        cpu_en = ~bp_match;
        if (!run)          state_d = S_HALT;
        else if (bp_match) state_d = S_BRK;
      end
      S_STEP: begin
        cpu_en = 1'b1;
        if (!stall) state_d = S_HALT;
      end
      S_BRK: begin
        if (!run)            state_d = S_HALT;
        else if (step_pulse) state_d = S_STEP;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q <= 1'b0;
    end else if (state_q == S_HALT && state_d == S_RUN) begin
      skip_q <= 1'b1;
    end else if (cpu_en) begin
      skip_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign halted  = (state_q == S_HALT) || (state_q == S_BRK);
  assign brk_hit = (state_q == S_BRK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic        brk_en;
  logic [31:0] brk_addr;
  logic [31:0] pc;
  logic        stall;
  logic        cpu_en;
  logic        halted;
  logic        brk_hit;
  logic [31:0] cycle_cnt;

  logic        pc_ld;
  logic [31:0] pc_ld_val;
  int          cyc;
  int          checks;
  int          fails;
  int          en_seen;

  typedef struct packed {
    int          cyc;
    logic        en;
    logic        halted;
    logic        brk;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  cpu_run_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .brk_en    (brk_en),
    .brk_addr  (brk_addr),
    .pc        (pc),
    .stall     (stall),
    .cpu_en    (cpu_en),
    .halted    (halted),
    .brk_hit   (brk_hit),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fetch-address model: PC advances by 4 on every enabled cycle unless the
  // stimulus forces a jump.
  initial pc = 32'd0;
  always @(posedge clk) begin
    if (pc_ld)       pc <= pc_ld_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected state for the current cycle; checked at the next falling edge.
  // The count of enabled cycles observed by the monitor must equal cnt too.
  task automatic chk(input string nm, input logic en, input logic h,
                     input logic b, input logic [31:0] cnt);
    exp_t e;
    e.cyc    = cyc;
    e.en     = en;
    e.halted = h;
    e.brk    = b;
    e.cnt    = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    exp_t  e;
    string nm;
    en_seen = 0;
    checks  = 0;
    fails   = 0;
    forever begin
      @(negedge clk);
      if (rst) en_seen = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          fails++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", nm, e.cyc, cyc);
        end else if (cpu_en !== e.en || halted !== e.halted || brk_hit !== e.brk ||
                     cycle_cnt !== e.cnt || en_seen != int'(e.cnt)) begin
          fails++;
          $display("FAIL %s: got en=%0b halted=%0b brk=%0b cnt=%0d seen=%0d, want en=%0b halted=%0b brk=%0b cnt=%0d seen=%0d",
                   nm, cpu_en, halted, brk_hit, cycle_cnt, en_seen,
                   e.en, e.halted, e.brk, e.cnt, e.cnt);
        end
      end
      if (!rst && cpu_en === 1'b1) en_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; stall = 1'b0;
    brk_en = 1'b0; brk_addr = 32'd0; pc_ld = 1'b1; pc_ld_val = 32'd0;
    repeat (2) tick();
    chk("reset", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    rst = 1'b0; pc_ld = 1'b0;
    tick();
    chk("halt_idle", 1'b0, 1'b1, 1'b0, 32'd0);

    // Continuous run for exactly 10 enabled cycles.
    run = 1'b1;
    tick(); chk("run_first", 1'b1, 1'b0, 1'b0, 32'd0);
    repeat (9) tick();
    run = 1'b0;
    chk("run_last", 1'b1, 1'b0, 1'b0, 32'd9);
    tick(); chk("run_stop", 1'b0, 1'b1, 1'b0, 32'd10);
    tick();

    // Three single steps, each giving one enabled cycle.
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(); tick();
      step = 1'b0;
      tick(); chk("step_wait", 1'b0, 1'b1, 1'b0, 32'(10 + i));
      tick(); chk("step_en",   1'b1, 1'b0, 1'b0, 32'(10 + i));
      tick(); chk("step_done", 1'b0, 1'b1, 1'b0, 32'(11 + i));
      repeat (3) tick();
    end

    // Step held in STEP by one stall cycle: two enabled cycles.
    step = 1'b1;
    tick(); tick();
    step = 1'b0; stall = 1'b1;
    tick();
    tick(); chk("stall_en0", 1'b1, 1'b0, 1'b0, 32'd13);
    tick(); stall = 1'b0; chk("stall_en1", 1'b1, 1'b0, 1'b0, 32'd14);
    tick(); chk("stall_done", 1'b0, 1'b1, 1'b0, 32'd15);
    tick();

    // Breakpoint at 0x10 running from pc=0.
    brk_en = 1'b1; brk_addr = 32'h10; pc_ld = 1'b1; pc_ld_val = 32'd0;
    tick();
    pc_ld = 1'b0; run = 1'b1;
    tick(); chk("bp_pc0", 1'b1, 1'b0, 1'b0, 32'd15);
    repeat (3) tick();
    chk("bp_pc0c", 1'b1, 1'b0, 1'b0, 32'd18);
    tick(); chk("bp_match", 1'b0, 1'b0, 1'b0, 32'd19);
    tick(); chk("bp_brk",   1'b0, 1'b1, 1'b1, 32'd19);
    tick(); chk("bp_hold",  1'b0, 1'b1, 1'b1, 32'd19);

    // Resume with run 1->0->1: pass 0x10 once, loop back, break again.
    run = 1'b0;
    tick(); chk("brk_to_halt", 1'b0, 1'b1, 1'b0, 32'd19);
    run = 1'b1;
    tick(); chk("skip_pass",  1'b1, 1'b0, 1'b0, 32'd19);
    tick(); chk("skip_clear", 1'b1, 1'b0, 1'b0, 32'd20);
    pc_ld = 1'b1; pc_ld_val = 32'h8;
    tick(); pc_ld = 1'b0; chk("loop_pc8", 1'b1, 1'b0, 1'b0, 32'd21);
    tick(); chk("loop_pcc",  1'b1, 1'b0, 1'b0, 32'd22);
    tick(); chk("bp_again",  1'b0, 1'b0, 1'b0, 32'd23);
    tick(); chk("brk_again", 1'b0, 1'b1, 1'b1, 32'd23);

    // Step out of BRK: one enabled cycle, then HALT.
    step = 1'b1;
    tick(); tick();
    step = 1'b0;
    tick(); chk("brk_step_wait", 1'b0, 1'b1, 1'b1, 32'd23);
    tick(); run = 1'b0; chk("brk_step_en", 1'b1, 1'b0, 1'b0, 32'd23);
    tick(); chk("brk_step_done", 1'b0, 1'b1, 1'b0, 32'd24);
    tick();

    // Match in the same cycle run drops: HALT wins, no BRK.
    pc_ld = 1'b1; pc_ld_val = 32'hC;
    tick();
    pc_ld = 1'b0; run = 1'b1;
    tick(); chk("race_run", 1'b1, 1'b0, 1'b0, 32'd24);
    tick(); run = 1'b0; chk("race_match", 1'b0, 1'b0, 1'b0, 32'd25);
    tick(); chk("race_halt", 1'b0, 1'b1, 1'b0, 32'd25);
    tick();

    // Asynchronous reset in the middle of a run.
    brk_en = 1'b0; run = 1'b1;
    tick(); chk("rr_run", 1'b1, 1'b0, 1'b0, 32'd25);
    repeat (6) tick();
    chk("rr_cnt6", 1'b1, 1'b0, 1'b0, 32'd31);
    tick();
    rst = 1'b1;
    chk("rr_async", 1'b0, 1'b1, 1'b0, 32'd0);
    tick(); chk("rr_hold", 1'b0, 1'b1, 1'b0, 32'd0);
    rst = 1'b0;
    tick(); chk("rr_resume", 1'b1, 1'b0, 1'b0, 32'd0);
    tick(); chk("rr_count",  1'b1, 1'b0, 1'b0, 32'd1);
    run = 1'b0;
    tick(); chk("rr_stop",   1'b0, 1'b1, 1'b0, 32'd2);

    repeat (3) tick();
    while (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL %s: expectation left unchecked, got none want sample at cycle %0d",
               name_q.pop_front(), exp_q.pop_front().cyc);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint controller for the 5-stage pipelined CPU. It produces the single enable that gates the PC register and all four pipeline register banks. The block gives the board three modes: continuous run, single-cycle step from a push-button, and halt on a fetch-address breakpoint. It also counts enabled cycles for the debug display.

## Interface
- CNT_W, 32, width of the enabled-cycle counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; continuous-run request (switch)
- step  in  1  raw push-button level, asynchronous to clk; each rising edge requests one step
- brk_en  in  1  breakpoint enable
- brk_addr  in  32  breakpoint fetch address (byte address)
- pc  in  32  current PC register output (fetch address)
- stall  in  1  load-use stall from the hazard unit
- cpu_en  out  1  enable for PC and IF/ID, ID/EX, EX/MEM, MEM/WB registers; combinational from state
- halted  out  1  high in HALT or BRK
- brk_hit  out  1  high in BRK
- cycle_cnt  out  CNT_W  count of cycles with cpu_en=1; wraps modulo 2^CNT_W

## Operation
- States: HALT, RUN, STEP, BRK. Reset state is HALT.
- step_pulse:
  - step passes through a 2-flop synchronizer.
  - A rising-edge detect on the synchronized level yields a one-cycle step_pulse.
- bp_match = brk_en & (pc == brk_addr) & ~skip. This is a full 32-bit compare.
- cpu_en:
  - RUN: cpu_en = ~bp_match.
  - STEP: cpu_en = 1.
  - HALT and BRK: cpu_en = 0.
- HALT:
  - run=1 → RUN, and skip is set.
  - else step_pulse → STEP.
  - run has priority over step_pulse.
- RUN:
  - run=0 → HALT. The cycle in which run is sampled low is still enabled.
  - else bp_match → BRK. cpu_en is 0 in the match cycle, so the instruction at brk_addr sits in IF and never enters ID.
  - step_pulse is ignored.
- STEP:
  - stall=0 → HALT. This gives exactly one enabled cycle in which the PC advances.
  - stall=1 → stay in STEP, with cpu_en held high, until a cycle with stall=0.
  - bp_match and step_pulse are ignored.
- BRK:
  - run=0 → HALT.
  - else step_pulse → STEP.
  - BRK never goes directly to RUN. Resuming from a breakpoint takes run 1→0→1.
- skip:
  - Set on the HALT→RUN transition.
  - Cleared at the end of the first enabled cycle.
  - Effect: resuming at brk_addr executes past it once, and the next encounter breaks again.
- cycle_cnt increments on every edge where cpu_en=1. It wraps from all-ones to 0.

## Timing
- Reset values while rst=1:
  - state = HALT
  - cpu_en = 0
  - halted = 1
  - brk_hit = 0
  - cycle_cnt = 0
  - skip = 0
  - synchronizer and edge flops = 0
- Reset is asynchronous and applies mid-operation from any state. Because the edge flops reset to 0, a step held high across reset release produces one pulse.
- step latency:
  - step first sampled high at edge k.
  - step_pulse is high in the cycle after edge k+2.
  - STEP is entered at edge k+3, and cpu_en is high in the following cycle.
- Breakpoint latency: cpu_en drops in the same cycle pc equals brk_addr (combinational). BRK is entered at the next edge.
- run latency: HALT→RUN at the first edge with run=1. cpu_en rises in the following cycle.
- Simultaneous events:
  - run=1 with step_pulse in HALT → RUN.
  - bp_match with run=0 in RUN → HALT. No BRK, brk_hit stays 0.

## Structure
- Package cpu_ctrl_pkg holds:
  - 2-bit state encoding: S_HALT=0, S_RUN=1, S_STEP=2, S_BRK=3.
  - CNT_W default.
- One sub-module, btn_edge: 2-flop synchronizer plus rising-edge detect, with async active-high reset. It is reusable for other board buttons.
- Top module: state register, skip flag, bp compare, cycle counter, output decode.

## Test plan
- Reset, then run=1 with brk_en=0 for 10 cycles, then run=0 → cpu_en high for exactly 10 cycles, cycle_cnt=10, halted=1.
- From HALT, pulse step 3 times, spaced ≥6 cycles, stall=0 → each press gives exactly one cpu_en cycle, cycle_cnt=3, state returns to HALT each time.
- brk_en=1, brk_addr=0x0000_0010, run=1 from pc=0, with pc modeled as +4 per enabled cycle:
  - cpu_en low when pc=0x10, brk_hit=1, cycle_cnt=4.
  - Then run 0→1: pc passes 0x10, and the next arrival at 0x10 breaks again.
- STEP with stall=1 for 1 cycle then 0 → cpu_en high for 2 consecutive cycles, then HALT, cycle_cnt+=2.
- In BRK, step pulse → one enabled cycle past brk_addr (pc 0x10→0x14), then HALT with brk_hit=0.
- Assert rst mid-RUN at cycle_cnt=7 → all outputs reach their reset values immediately. With run still 1, RUN resumes at the first edge after release, and counting restarts from 0.
